// File: rtl/expr_eval_if.sv
// ---------------------------------------------------------------------------
// expr_eval_if
// Purpose : Character-stream / result bundle shared between the character
//           source (master) and the incremental expression evaluator (slave).
// Signals :
//   in       [7:0]      ASCII character, meaningful only while in_valid=1
//   in_valid            one character per cycle, no backpressure
//   result   [WIDTH-1:0] value of the expression received so far
//   ok                  stream so far is a complete valid expression
//   err                 sticky syntax error
// ---------------------------------------------------------------------------
interface expr_eval_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       in;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             ok;
  logic             err;

  modport master (
    output in, in_valid,
    input  result, ok, err
  );

  modport slave (
    input  in, in_valid,
    output result, ok, err
  );
endinterface

// File: rtl/expr_eval.sv
// ---------------------------------------------------------------------------
// expr_eval
// Purpose : Incrementally evaluates a stream of single-digit operands and
//           +, -, (optionally) * operators with standard precedence. After
//           every accepted digit, result holds acc + term, where acc is the
//           sum of finished terms and term is the current signed product.
// Ports   :
//   clk          rising-edge clock
//   clr          asynchronous active-high clear of all state and outputs
//   bus (slave)  in / in_valid character input, result / ok / err outputs
// Build option:
//   EXPR_EVAL_MUL_EN  defined   -> '*' accepted, multiplier present
//                     undefined -> '*' is an illegal character
// ---------------------------------------------------------------------------
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        clr,
  expr_eval_if.slave  bus
);

  typedef enum logic [1:0] {S_NUM, S_OP, S_ERR} state_t;

`ifdef EXPR_EVAL_MUL_EN
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;
`else
  typedef enum logic [0:0] {OP_ADD, OP_SUB} op_t;
`endif

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_result;
  logic             r_ok;
  logic             r_err;

  logic             w_is_digit;
  logic             w_is_op;
  op_t              w_op_sel;
  logic [WIDTH-1:0] w_digit;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_term_next;

  assign w_is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  // ASCII '0'..'9' carry their value in the low nibble.
  assign w_digit    = {{(WIDTH-4){1'b0}}, bus.in[3:0]};

  // Operator decode; '*' is only recognised when the multiplier is built.
  always_comb begin
    w_is_op  = 1'b0;
    w_op_sel = OP_ADD;
    case (bus.in)
      8'h2B: begin w_is_op = 1'b1; w_op_sel = OP_ADD; end
      8'h2D: begin w_is_op = 1'b1; w_op_sel = OP_SUB; end
`ifdef EXPR_EVAL_MUL_EN
      8'h2A: begin w_is_op = 1'b1; w_op_sel = OP_MUL; end
`endif
      default: ;
    endcase
  end

  // Next arithmetic values for an accepted digit. The reset values
  // (acc=0, term=0, op=ADD) make the first digit fall out of the ADD case.
  always_comb begin
    w_acc_next  = r_acc + r_term;
    w_term_next = w_digit;
    case (r_op)
      OP_ADD: w_term_next = w_digit;
      OP_SUB: w_term_next = -w_digit;
`ifdef EXPR_EVAL_MUL_EN
      OP_MUL: begin
        // Pending product keeps growing; finished terms stay untouched.
        w_acc_next  = r_acc;
        w_term_next = r_term * w_digit;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_NUM;
      r_op     <= OP_ADD;
      r_acc    <= '0;
      r_term   <= '0;
      r_result <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else if (bus.in_valid) begin
      case (r_state)
        S_NUM: begin
          if (w_is_digit) begin
            r_acc    <= w_acc_next;
            r_term   <= w_term_next;
            r_result <= w_acc_next + w_term_next;
            r_state  <= S_OP;
            r_ok     <= 1'b1;
          end else begin
            r_state  <= S_ERR;
            r_ok     <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        S_OP: begin
          if (w_is_op) begin
            r_op    <= w_op_sel;
            r_state <= S_NUM;
            r_ok    <= 1'b0;
          end else begin
            r_state <= S_ERR;
            r_ok    <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: ; // S_ERR absorbs everything until clr
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.ok     = r_ok;
  assign bus.err    = r_err;

endmodule
